// File: rtl/elevator_request_queue.sv
// elevator_request_queue: latches call-button presses into a per-floor pending bitmap and runs the door dwell for each stop.
//   inputs:  clk, reset (sync, active-high), call_btn[6:0], current_floor[2:0], floor_valid
//   outputs: queue_status[6:0], stop_here, door_open, svc_done, busy, floor_err
//   optional: ELEVATOR_QUEUE_CANCEL_EN enables toggle-cancel of pending floors while travelling
module elevator_request_queue #(
  parameter int DWELL_CYCLES = 16,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] call_btn,
  input  logic [2:0] current_floor,
  input  logic       floor_valid,
  output logic [6:0] queue_status,
  output logic       stop_here,
  output logic       door_open,
  output logic       svc_done,
  output logic       busy,
  output logic       floor_err
);
  typedef enum logic [1:0] {TRAVEL, DWELL, CLOSE} state_t;
  state_t state, state_nx;
  logic [6:0] prev_btn, rise, hit_mask, served_mask, qs_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0] served;
  logic hit;
  assign rise = call_btn & ~prev_btn;
  assign hit_mask = (current_floor == 3'd7) ? 7'd0 : 7'd1 << current_floor;
  assign served_mask = 7'd1 << served;
  // a same-cycle rising edge on the arrival floor counts as a request
  assign hit = floor_valid && state == TRAVEL && |(hit_mask & (queue_status | rise));
  assign door_open = state == DWELL;
  assign svc_done = state == CLOSE;
  assign busy = door_open | svc_done;
  always_comb begin
    state_nx = state;
    qs_nx = queue_status | rise;
    if (state == TRAVEL) begin
      state_nx = hit ? DWELL : TRAVEL;
`ifdef ELEVATOR_QUEUE_CANCEL_EN
      qs_nx = queue_status ^ rise;
`endif
      qs_nx = hit ? qs_nx & ~hit_mask : qs_nx;
    end else if (state == DWELL) begin
      state_nx = (cnt == '0) ? CLOSE : DWELL;
      qs_nx = queue_status | (rise & ~served_mask);
    end else begin
      state_nx = TRAVEL;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= TRAVEL;
      queue_status <= '0;
      prev_btn <= '0;
      cnt <= '0;
      served <= '0;
      stop_here <= 1'b0;
      floor_err <= 1'b0;
    end else begin
      state <= state_nx;
      queue_status <= qs_nx;
      prev_btn <= call_btn;
      stop_here <= hit;
      if (hit) begin
        cnt <= CNT_W'(DWELL_CYCLES - 1);
        served <= current_floor;
      end else if (state == DWELL && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == TRAVEL && floor_valid && current_floor == 3'd7) floor_err <= 1'b1;
    end
  end
endmodule
